regwrite_decoder: RTL and testbench

Write-side counterpart of the register-file read-select muxes. It accepts register write requests (address plus data) from the writeback stage through a valid/ready handshake. Requests are buffered in a 2-entry skid queue and decoded into a registered one-hot write-enable vector with aligned write data for the 32-entry register file. Writes to the zero register (X31) are discarded and never reach the file.

---
 rtl/regwrite_decoder.sv | 141 ++++++++++++++
 tb/tb_regwrite_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_decoder.sv
// regwrite_decoder
//   Takes register write requests from writeback through a valid/ready
//   handshake and buffers them in a 2-entry FIFO. Each pop drives a
//   registered one-hot write enable plus aligned data into the register file.
//   Writes to ZERO_REG, and to addresses >= NUM_REGS, are dropped.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   wr_valid/wr_ready   request handshake (wr_ready is registered)
//   wr_addr, wr_data    destination register and write data
//   drain_en            register file can take a write this cycle
//   en_out, data_out    registered one-hot write enable and data
//   zero_drop           one-cycle pulse after a ZERO_REG request is discarded
//   occupancy           entries held in the queue (0..2)
//
// Optional feature (macro REGWRITE_FWD_EN)
//   rd_addr, fwd_hit, fwd_data: combinational lookup of pending writes.
//   The youngest match wins: tail, then head, then the output register.
module regwrite_decoder #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                drain_en,
  output logic [NUM_REGS-1:0] en_out,
  output logic [DATA_W-1:0]   data_out,
  output logic                zero_drop,
  output logic [1:0]          occupancy
`ifdef REGWRITE_FWD_EN
  ,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                fwd_hit,
  output logic [DATA_W-1:0]   fwd_data
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  localparam logic [ADDR_W-1:0] ZERO_A     = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) r[i] = (a == ADDR_W'(i));
    return r;
  endfunction

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] h_addr, t_addr;
  logic [DATA_W-1:0] h_data, t_data;
  logic              accept, is_zero, in_range, push, pop;

  assign occupancy = state;
  assign accept    = wr_valid & wr_ready;
  assign is_zero   = (wr_addr == ZERO_A);
  assign in_range  = ({1'b0, wr_addr} < NUM_REGS_W);
  assign push      = accept & ~is_zero & in_range;
  assign pop       = drain_en & (state != EMPTY);

  // The state encoding equals the entry count, so it steps by +/-1.
  always_comb begin
    state_nxt = state;
    case ({push, pop})
      2'b10:   state_nxt = state + 2'd1;
      2'b01:   state_nxt = state - 2'd1;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      wr_ready  <= 1'b1;
      zero_drop <= 1'b0;
      en_out    <= '0;
      data_out  <= '0;
      h_addr    <= '0;
      h_data    <= '0;
      t_addr    <= '0;
      t_data    <= '0;
    end else begin
      state     <= state_nxt;
      wr_ready  <= (state_nxt != TWO);
      zero_drop <= accept & is_zero;

      if (pop) begin
        en_out   <= onehot(h_addr);
        data_out <= h_data;
      end else begin
        en_out   <= '0;
      end

      if (pop && state == TWO) begin
        h_addr <= t_addr;
        h_data <= t_data;
      end

      // A new entry lands in the head slot when the head is (or becomes)
      // free this edge; otherwise it goes behind the surviving head.
      if (push) begin
        if (state == EMPTY || (state == ONE && pop)) begin
          h_addr <= wr_addr;
          h_data <= wr_data;
        end else begin
          t_addr <= wr_addr;
          t_data <= wr_data;
        end
      end
    end
  end

`ifdef REGWRITE_FWD_EN
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (rd_addr != ZERO_A) begin
      if (state == TWO && t_addr == rd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = t_data;
      end else if (state != EMPTY && h_addr == rd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = h_data;
      end else if (|(en_out & onehot(rd_addr))) begin
        fwd_hit  = 1'b1;
        fwd_data = data_out;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regwrite_decoder.sv
module tb_regwrite_decoder;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        drain_en = 1'b1;
  logic [31:0] en_out;
  logic [63:0] data_out;
  logic        zero_drop;
  logic [1:0]  occupancy;
`ifdef REGWRITE_FWD_EN
  logic [4:0]  rd_addr = '0;
  logic        fwd_hit;
  logic [63:0] fwd_data;
`endif

  int  ncmp = 0;
  int  nfail = 0;
  wr_t sb[$];

  regwrite_decoder #(.ADDR_W(5), .DATA_W(64), .NUM_REGS(32), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .drain_en(drain_en),
    .en_out(en_out), .data_out(data_out), .zero_drop(zero_drop),
    .occupancy(occupancy)
`ifdef REGWRITE_FWD_EN
    , .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for wr_ready, then let it be accepted.
  task automatic send(input logic [4:0] a, input logic [63:0] d);
    int n;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    n = 0;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'(wr_ready), 64'd1);
    tick();
    if (a != 5'd31) sb.push_back('{addr: a, data: d});
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: every write seen must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && en_out != '0) begin
      chk("onehot", 64'($onehot(en_out)), 64'd1);
      chk("zero_bit", 64'(en_out[31]), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_write", 64'(en_out), 64'd0);
      end else begin
        wr_t e;
        logic [31:0] ee;
        e  = sb.pop_front();
        ee = 32'h1 << e.addr;
        chk("sb_en", 64'(en_out), 64'(ee));
        chk("sb_data", data_out, e.data);
      end
    end
  end

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_en", 64'(en_out), 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ready", 64'(wr_ready), 64'd1);
    chk("rst_zd", 64'(zero_drop), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: single write, 2-cycle latency, one-cycle enable
    drain_en = 1'b1;
    send(5'd5, 64'hDEAD_BEEF);
    chk("t1_occ_after_acc", 64'(occupancy), 64'd1);
    chk("t1_en_early", 64'(en_out), 64'd0);
    tick();
    chk("t1_en", 64'(en_out), 64'h0000_0020);
    chk("t1_data", data_out, 64'hDEAD_BEEF);
    chk("t1_occ", 64'(occupancy), 64'd0);
    tick();
    chk("t1_en_clear", 64'(en_out), 64'd0);
    chk("t1_data_hold", data_out, 64'hDEAD_BEEF);

    // 2: stall fills queue, third request held, then ordered drain
    drain_en = 1'b0;
    send(5'd3, 64'h33);
    send(5'd7, 64'h77);
    chk("t2_occ2", 64'(occupancy), 64'd2);
    chk("t2_ready0", 64'(wr_ready), 64'd0);
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 64'h99;
    tick();
    tick();
    chk("t2_held_occ", 64'(occupancy), 64'd2);
    chk("t2_held_ready", 64'(wr_ready), 64'd0);
    chk("t2_stall_en", 64'(en_out), 64'd0);
    drain_en = 1'b1;
    send(5'd9, 64'h99);
    chk("t2_en7", 64'(en_out), 64'h0000_0080);
    tick();
    chk("t2_en9", 64'(en_out), 64'h0000_0200);
    wait_drain();

    // 3: zero register filter
    tick();
    send(5'd31, 64'h1);
    chk("t3_zd", 64'(zero_drop), 64'd1);
    chk("t3_occ", 64'(occupancy), 64'd0);
    chk("t3_en", 64'(en_out), 64'd0);
    tick();
    chk("t3_zd_pulse", 64'(zero_drop), 64'd0);
    chk("t3_en2", 64'(en_out), 64'd0);

    // 4: back-to-back stream, full throughput
    for (int a = 0; a <= 10; a++) begin
      send(5'(a), 64'h1000 + 64'(a));
      chk("t4_occ_le1", 64'(occupancy <= 2'd1), 64'd1);
      chk("t4_ready", 64'(wr_ready), 64'd1);
    end
    wait_drain();

    // 5: asynchronous reset with a full queue
    drain_en = 1'b0;
    send(5'd3, 64'h333);
    send(5'd7, 64'h777);
    chk("t5_occ2", 64'(occupancy), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("t5_en", 64'(en_out), 64'd0);
    chk("t5_occ", 64'(occupancy), 64'd0);
    chk("t5_ready", 64'(wr_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    drain_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_write", 64'(en_out), 64'd0);
    end

`ifdef REGWRITE_FWD_EN
    // 6: forwarding picks the youngest pending write
    drain_en = 1'b0;
    send(5'd4, 64'h11);
    send(5'd4, 64'h22);
    rd_addr = 5'd4;
    #1;
    chk("t6_hit", 64'(fwd_hit), 64'd1);
    chk("t6_data", fwd_data, 64'h22);
    rd_addr = 5'd31;
    #1;
    chk("t6_zero_hit", 64'(fwd_hit), 64'd0);
    drain_en = 1'b1;
    wait_drain();
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
